seg7_scan_decoder: RTL and testbench

SEG7_SCAN_DECODER -- requirements
Module: seg7_scan_decoder

---
 rtl/seg7_pkg.sv | 37 +++
 rtl/seg7_pattern_decode.sv | 32 +++
 rtl/seg7_scan_decoder.sv | 150 +++++++++++++++
 tb/tb_seg7_scan_decoder.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared constants, state type and helpers for the 7-segment scan decoder.
package seg7_pkg;

  localparam logic [6:0] SEG_0     = 7'b1111110;
  localparam logic [6:0] SEG_1     = 7'b0110000;
  localparam logic [6:0] SEG_2     = 7'b1101101;
  localparam logic [6:0] SEG_3     = 7'b1111001;
  localparam logic [6:0] SEG_4     = 7'b0110011;
  localparam logic [6:0] SEG_5     = 7'b1011011;
  localparam logic [6:0] SEG_6     = 7'b1011111;
  localparam logic [6:0] SEG_7     = 7'b1110000;
  localparam logic [6:0] SEG_8     = 7'b1111111;
  localparam logic [6:0] SEG_9     = 7'b1111011;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  localparam logic [3:0] DIGIT_BLANK = 4'hA;
  localparam logic [3:0] DIGIT_ERR   = 4'hF;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    HOLD   = 2'd2
  } state_t;

  function automatic logic is_onehot8(input logic [7:0] v);
    return (v != 8'h00) && ((v & (v - 8'd1)) == 8'h00);
  endfunction

  function automatic logic [2:0] onehot_idx(input logic [7:0] v);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 0; i < 8; i++)
      if (v[i]) idx = i[2:0];
    return idx;
  endfunction

endpackage

// File: rtl/seg7_pattern_decode.sv
// Combinational segment-pattern to digit-code lookup.
module seg7_pattern_decode
  import seg7_pkg::*;
(
  input  logic [6:0] seg7,
  output logic [3:0] code,
  output logic       is_blank
);

  always_comb begin
    code     = DIGIT_ERR;
    is_blank = 1'b0;
    case (seg7)
      SEG_0:     code = 4'd0;
      SEG_1:     code = 4'd1;
      SEG_2:     code = 4'd2;
      SEG_3:     code = 4'd3;
      SEG_4:     code = 4'd4;
      SEG_5:     code = 4'd5;
      SEG_6:     code = 4'd6;
      SEG_7:     code = 4'd7;
      SEG_8:     code = 4'd8;
      SEG_9:     code = 4'd9;
      SEG_BLANK: begin
        code     = DIGIT_BLANK;
        is_blank = 1'b1;
      end
      default:   code = DIGIT_ERR;
    endcase
  end

endmodule

// File: rtl/seg7_scan_decoder.sv
// Recovers a full 8-digit frame from a multiplexed 7-segment display scan.
// Optional macro SEG7_DEC_ERRCNT_EN adds a saturating err_count output.
//
// state  | meaning
// IDLE   | cat not a single active-low select
// SETTLE | counting cycles of unchanged {cat,seg7,dp}
// HOLD   | digit captured, waiting for the inputs to change
module seg7_scan_decoder
  import seg7_pkg::*;
#(
  parameter int STABLE_CYC = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  seg7,
  input  logic        dp,
  input  logic [7:0]  cat,
`ifdef SEG7_DEC_ERRCNT_EN
  output logic [7:0]  err_count,
`endif
  output logic [31:0] digits,
  output logic [7:0]  dps,
  output logic [7:0]  blank,
  output logic        frame_valid,
  output logic        pattern_err
);

  localparam logic [3:0] STABLE_TGT = 4'(STABLE_CYC);

  state_t      state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic [15:0] prev;
  logic [15:0] cur;
  logic        changed;
  logic        cat_valid;
  logic [2:0]  sel_idx;
  logic        capture;
  logic [3:0]  dec_code;
  logic        dec_blank;
  logic [31:0] sh_digits;
  logic [7:0]  sh_dps;
  logic [7:0]  sh_blank;
  logic [7:0]  mask;

  assign cur       = {cat, seg7, dp};
  assign changed   = (cur != prev);
  assign cat_valid = is_onehot8(~cat);
  assign sel_idx   = onehot_idx(~cat);

  seg7_pattern_decode u_decode (
    .seg7     (seg7),
    .code     (dec_code),
    .is_blank (dec_blank)
  );

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    capture   = 1'b0;
    case (state)
      IDLE: begin
        if (cat_valid) begin
          cnt_nxt = 4'd1;
          if (STABLE_TGT == 4'd1) begin
            capture   = 1'b1;
            state_nxt = HOLD;
          end else begin
            state_nxt = SETTLE;
          end
        end
      end
      SETTLE: begin
        if (!cat_valid) begin
          cnt_nxt   = 4'd0;
          state_nxt = IDLE;
        end else if (changed) begin
          // a change always restarts the count, even on the would-be capture cycle
          cnt_nxt = 4'd1;
        end else begin
          cnt_nxt = cnt + 4'd1;
          if (cnt_nxt >= STABLE_TGT) begin
            capture   = 1'b1;
            state_nxt = HOLD;
          end
        end
      end
      HOLD: begin
        if (changed) begin
          if (cat_valid) begin
            cnt_nxt   = 4'd1;
            state_nxt = SETTLE;
          end else begin
            cnt_nxt   = 4'd0;
            state_nxt = IDLE;
          end
        end
      end
      default: begin
        cnt_nxt   = 4'd0;
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= 4'd0;
      prev        <= 16'h0000;
      sh_digits   <= 32'h0;
      sh_dps      <= 8'h00;
      sh_blank    <= 8'h00;
      mask        <= 8'h00;
      digits      <= 32'h0;
      dps         <= 8'h00;
      blank       <= 8'h00;
      frame_valid <= 1'b0;
      pattern_err <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      prev        <= cur;
      frame_valid <= (mask == 8'hFF);
      pattern_err <= capture && (dec_code == DIGIT_ERR);
      if (capture) begin
        sh_digits[sel_idx*4 +: 4] <= dec_code;
        sh_dps[sel_idx]           <= dp;
        sh_blank[sel_idx]         <= dec_blank;
      end
      if (mask == 8'hFF) begin
        digits <= sh_digits;
        dps    <= sh_dps;
        blank  <= sh_blank;
        mask   <= capture ? (8'(1) << sel_idx) : 8'h00;
      end else if (capture) begin
        mask[sel_idx] <= 1'b1;
      end
    end
  end

`ifdef SEG7_DEC_ERRCNT_EN
  always_ff @(posedge clk) begin
    if (rst)
      err_count <= 8'h00;
    else if (pattern_err && (err_count != 8'hFF))
      err_count <= err_count + 8'd1;
  end
`endif

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Directed bench for seg7_scan_decoder (STABLE_CYC = 4), hand-computed expectations.
module tb_seg7_scan_decoder;
  import seg7_pkg::*;

  logic        clk;
  logic        rst;
  logic [6:0]  seg7;
  logic        dp;
  logic [7:0]  cat;
  logic [31:0] digits;
  logic [7:0]  dps;
  logic [7:0]  blank;
  logic        frame_valid;
  logic        pattern_err;
`ifdef SEG7_DEC_ERRCNT_EN
  logic [7:0]  err_count;
`endif

  int n_cmp = 0;
  int n_err = 0;
  int fv_cnt = 0;
  int perr_cnt = 0;
  int fv_base;
  int perr_base;

  logic [6:0] pat [10] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
                           7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011};

  seg7_scan_decoder #(.STABLE_CYC(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .seg7        (seg7),
    .dp          (dp),
    .cat         (cat),
`ifdef SEG7_DEC_ERRCNT_EN
    .err_count   (err_count),
`endif
    .digits      (digits),
    .dps         (dps),
    .blank       (blank),
    .frame_valid (frame_valid),
    .pattern_err (pattern_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (frame_valid) fv_cnt++;
    if (pattern_err) perr_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic show(input int idx, input logic [6:0] p, input logic d, input int n);
    cat  = ~(8'(1) << idx);
    seg7 = p;
    dp   = d;
    repeat (n) @(negedge clk);
  endtask

  task automatic idle(input int n);
    cat  = 8'hFF;
    seg7 = 7'b0;
    dp   = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic snap();
    fv_base   = fv_cnt;
    perr_base = perr_cnt;
  endtask

  initial begin
    rst  = 1'b1;
    cat  = 8'hFF;
    seg7 = 7'b0;
    dp   = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_digits", digits, 32'h0);
    check("rst_dps", {24'h0, dps}, 32'h0);
    check("rst_blank", {24'h0, blank}, 32'h0);
    check("rst_fv", {31'h0, frame_valid}, 32'h0);
    check("rst_perr", {31'h0, pattern_err}, 32'h0);
    check("rst_state", 32'(dut.state), 32'(IDLE));
    rst = 1'b0;
    idle(2);

    // full frame 0..7, dp on digit 2; frame pulse one cycle after last capture
    snap();
    for (int i = 0; i < 7; i++) show(i, pat[i], i == 2, 6);
    show(7, pat[7], 1'b0, 4);
    check("fv_early", {31'h0, frame_valid}, 32'h0);
    @(negedge clk);
    check("fv_latency", {31'h0, frame_valid}, 32'h1);
    show(7, pat[7], 1'b0, 1);
    idle(3);
    check("frame1_fv_cnt", fv_cnt - fv_base, 1);
    check("frame1_digits", digits, 32'h76543210);
    check("frame1_dps", {24'h0, dps}, 32'h04);
    check("frame1_blank", {24'h0, blank}, 32'h0);
    check("frame1_perr", perr_cnt - perr_base, 0);

    // digit 3 shown too briefly; digit 1 blank
    snap();
    show(0, pat[0], 1'b0, 6);
    show(1, SEG_BLANK, 1'b0, 6);
    show(2, pat[2], 1'b0, 6);
    show(3, pat[3], 1'b0, 3);
    for (int i = 4; i < 8; i++) show(i, pat[i], 1'b0, 6);
    idle(3);
    check("short_d3_no_frame", fv_cnt - fv_base, 0);
    show(3, pat[3], 1'b0, 6);
    idle(3);
    check("d3_completes_frame", fv_cnt - fv_base, 1);
    check("frame2_digits", digits, 32'h765432A0);
    check("frame2_blank", {24'h0, blank}, 32'h02);
    check("frame2_dps", {24'h0, dps}, 32'h0);

    // change on the would-be capture cycle: second pattern wins
    snap();
    show(0, pat[4], 1'b0, 3);
    show(0, pat[9], 1'b0, 6);
    // illegal pattern on digit 5
    show(1, pat[9], 1'b0, 6);
    show(2, pat[8], 1'b0, 6);
    show(3, pat[9], 1'b0, 6);
    show(4, pat[8], 1'b0, 6);
    show(5, 7'b1010101, 1'b0, 5);
    show(6, pat[8], 1'b0, 6);
    show(7, pat[9], 1'b0, 6);
    idle(3);
    check("frame3_fv_cnt", fv_cnt - fv_base, 1);
    check("frame3_digits", digits, 32'h98F89899);
    check("frame3_perr_cnt", perr_cnt - perr_base, 1);
`ifdef SEG7_DEC_ERRCNT_EN
    check("err_count_1", {24'h0, err_count}, 32'h1);
`endif

    // two lows on cat: ignored
    snap();
    for (int i = 0; i < 7; i++) show(i, pat[i], 1'b0, 6);
    cat  = 8'b11110011;
    seg7 = pat[8];
    dp   = 1'b1;
    repeat (20) @(negedge clk);
    check("two_low_state", 32'(dut.state), 32'(IDLE));
    check("two_low_no_fv", fv_cnt - fv_base, 0);
    check("two_low_no_perr", perr_cnt - perr_base, 0);
    show(7, pat[7], 1'b0, 6);
    idle(3);
    check("frame4_fv_cnt", fv_cnt - fv_base, 1);
    check("frame4_digits", digits, 32'h76543210);
    check("frame4_dps", {24'h0, dps}, 32'h0);

    // reset after 5 captures discards them; recapture overwrites
    snap();
    for (int i = 0; i < 5; i++) show(i, pat[i], 1'b0, 6);
    do_reset();
    @(negedge clk);
    check("midrst_digits", digits, 32'h0);
`ifdef SEG7_DEC_ERRCNT_EN
    check("midrst_err_count", {24'h0, err_count}, 32'h0);
`endif
    show(5, pat[5], 1'b0, 6);
    show(6, pat[6], 1'b0, 6);
    show(7, pat[7], 1'b0, 6);
    show(0, pat[1], 1'b0, 6);
    idle(3);
    check("midrst_no_fv", fv_cnt - fv_base, 0);
    show(0, pat[5], 1'b0, 6);
    for (int i = 1; i < 5; i++) show(i, pat[i], 1'b0, 6);
    idle(3);
    check("frame5_fv_cnt", fv_cnt - fv_base, 1);
    check("frame5_digits", digits, 32'h76543215);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
